round_robin_grant_controller: RTL
=================================

// Module: round_robin_grant_controller
// PURPOSE
//   Arbitrates N requesters for one shared resource, fair round-robin.
//   Drives grantIndex straight into Demultiplexer/Multiplexer select lines; busy qualifies it.
//   Holds a grant until the owner drops its request, or a watchdog timeout fires.
//   Always one idle turnaround cycle between two consecutive owners.
// PARAMETERS
//   NUMBER_OF_REQUESTERS  4                              requester count, >= 2
//   SELECT_WIDTH          $clog2(NUMBER_OF_REQUESTERS)   width of grantIndex
//   MAX_HOLD_CYCLES       16                             watchdog limit in cycles; 0 disables it
//   COUNTER_WIDTH         $clog2(MAX_HOLD_CYCLES+1)      width of the hold counter
// PORTS
//   clock        input   1                        rising-edge clock
//   reset        input   1                        synchronous, active-high
//   requests     input   NUMBER_OF_REQUESTERS     per-requester level request
//   grants       output  NUMBER_OF_REQUESTERS     one-hot grant, registered; all zero when idle
//   grantIndex   output  SELECT_WIDTH             index of current/last owner, registered
//   busy         output  1                        1 while a grant is held
//   timeout      output  1                        1-cycle pulse when the watchdog revokes a grant
// BEHAVIOUR
//   Reset (sampled at clock edge while reset=1):
//     - state=IDLE, grants=0, grantIndex=0, busy=0, timeout=0
//     - priority pointer=0, hold counter=0
//     - reset mid-grant drops the grant at the next edge, no timeout pulse
//   States: IDLE, GRANTED
//   IDLE:
//     - if requests!=0, scan from pointer, pointer+1, ... mod N; first set bit is winner w
//     - next edge: state=GRANTED, grants=1<<w, grantIndex=w, busy=1, counter=0
//     - latency: request sampled at edge k -> grant visible after edge k (1 cycle)
//   GRANTED, evaluated each edge, first match wins:
//     - requests[grantIndex]==0 -> release:
//       IDLE, grants=0, busy=0, pointer=(grantIndex+1) mod N
//     - MAX_HOLD_CYCLES!=0 and counter==MAX_HOLD_CYCLES-1 -> revoke:
//       IDLE, grants=0, busy=0, timeout=1 for that one cycle, pointer=(grantIndex+1) mod N
//     - else counter+=1, outputs unchanged
//   Hold limit: grant lasts at most MAX_HOLD_CYCLES cycles.
//   Requests from non-owners during GRANTED are ignored; they are only evaluated in IDLE.
//   Turnaround: after release/revoke, IDLE lasts exactly 1 cycle if requests remain.
//   grantIndex keeps last owner in IDLE; consumers must qualify it with busy.
//   Pointer wraps N-1 -> 0. Pointer update is the plain increment; N need not be a power of 2.
//   Starvation bound: a steadily requesting index waits
//     <= (N-1)*(MAX_HOLD_CYCLES+1) cycles.
//   Invariants:
//     - $onehot0(grants)
//     - busy == |grants
//     - timeout implies !busy in the same cycle
// TESTING
//   1. Reset hold 3 cycles, requests=0 -> grants=0, busy=0, grantIndex=0, timeout=0.
//   2. Single requester: requests=4'b0100 at edge k -> grants=0100, grantIndex=2 after edge k;
//      drop request -> grants=0 next edge, pointer=3.
//   3. Round robin, N=4: requests=4'b1111 held; each owner drops its request for 1 cycle
//      after 2 cycles granted -> grant order 0,1,2,3,0, one idle cycle between grants.
//   4. Timeout, MAX_HOLD_CYCLES=16: requests=4'b0001 held -> grants=0001 for exactly 16 cycles,
//      then grants=0, timeout=1 for 1 cycle, regrant to 0 after 1 idle cycle.
//   5. Fairness after timeout: requests=4'b0011, 0 hogs -> after timeout requester 1 granted
//      before 0; check the starvation bound.
//   6. Reset mid-grant: assert reset while grants=1000 -> next edge grants=0, busy=0,
//      timeout=0, pointer=0; with MAX_HOLD_CYCLES=0, hold 100 cycles -> never timeout.

Source files
------------

// File: rtl/round_robin_grant_controller.sv
// ---------------------------------------------------------------------------
// round_robin_grant_controller
//
// Fair round-robin arbiter handing one shared resource to one of N requesters.
// A grant is held until its owner drops the request or, when enabled, a hold
// watchdog revokes it. There is always exactly one idle turnaround cycle
// between two consecutive owners, so a downstream mux/demux never switches
// select while busy is high.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no owner; requests are scanned from the priority pointer
// ST_GRANTED | one owner holds the resource; other requests are ignored
//
// Ports
//   clock_i        rising-edge clock
//   reset_i        synchronous, active-high reset
//   requests_i     per-requester level request
//   grants_o       one-hot grant (registered), all zero when idle
//   grant_index_o  index of current/last owner (registered); qualify with busy_o
//   busy_o         high while a grant is held
//   timeout_o      one-cycle pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
module round_robin_grant_controller #(
    parameter int NUMBER_OF_REQUESTERS = 4,
    parameter int SELECT_WIDTH         = $clog2(NUMBER_OF_REQUESTERS),
    parameter int MAX_HOLD_CYCLES      = 16,
    parameter int COUNTER_WIDTH        = $clog2(MAX_HOLD_CYCLES + 1)
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic [NUMBER_OF_REQUESTERS-1:0] requests_i,
    output logic [NUMBER_OF_REQUESTERS-1:0] grants_o,
    output logic [SELECT_WIDTH-1:0]         grant_index_o,
    output logic                            busy_o,
    output logic                            timeout_o
);

    // With the watchdog disabled the counter width collapses to zero; keep a
    // one-bit register so the design stays legal. It is never advanced then.
    localparam int CNT_W = (COUNTER_WIDTH < 1) ? 1 : COUNTER_WIDTH;
    localparam bit WATCHDOG_EN = (MAX_HOLD_CYCLES != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST =
        WATCHDOG_EN ? CNT_W'(MAX_HOLD_CYCLES - 1) : '0;
    localparam logic [SELECT_WIDTH-1:0] LAST_INDEX =
        SELECT_WIDTH'(NUMBER_OF_REQUESTERS - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t                            state_q, state_d;
    logic [NUMBER_OF_REQUESTERS-1:0]   grants_q, grants_d;
    logic [SELECT_WIDTH-1:0]           grant_index_q, grant_index_d;
    logic                              busy_q, busy_d;
    logic                              timeout_q, timeout_d;
    logic [SELECT_WIDTH-1:0]           pointer_q, pointer_d;
    logic [CNT_W-1:0]                  counter_q, counter_d;

    logic                              win_found;
    logic [SELECT_WIDTH-1:0]           win_index;
    logic [SELECT_WIDTH-1:0]           scan_index;
    logic [SELECT_WIDTH-1:0]           next_pointer;

    // base + offset modulo N; both operands are below N so a single
    // conditional subtract suffices, which keeps non-power-of-two N correct.
    function automatic logic [SELECT_WIDTH-1:0] wrap_add(
        input logic [SELECT_WIDTH-1:0] base,
        input int unsigned             offset
    );
        int unsigned sum;
        sum = 32'(base) + offset;
        if (sum >= 32'(NUMBER_OF_REQUESTERS)) begin
            sum = sum - 32'(NUMBER_OF_REQUESTERS);
        end
        return SELECT_WIDTH'(sum);
    endfunction

    // Winner scan: first set request at pointer, pointer+1, ... wrapping.
    always_comb begin
        win_found  = 1'b0;
        win_index  = pointer_q;
        scan_index = pointer_q;
        for (int i = 0; i < NUMBER_OF_REQUESTERS; i++) begin
            scan_index = wrap_add(pointer_q, i);
            if (!win_found && requests_i[scan_index]) begin
                win_found = 1'b1;
                win_index = scan_index;
            end
        end
    end

    // Priority moves just past the owner that is leaving.
    assign next_pointer = (grant_index_q == LAST_INDEX) ? '0
                        : grant_index_q + SELECT_WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        grants_d      = grants_q;
        grant_index_d = grant_index_q;
        busy_d        = busy_q;
        timeout_d     = 1'b0;
        pointer_d     = pointer_q;
        counter_d     = counter_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d             = ST_GRANTED;
                    grants_d            = '0;
                    grants_d[win_index] = 1'b1;
                    grant_index_d       = win_index;
                    busy_d              = 1'b1;
                    counter_d           = '0;
                end
            end
            ST_GRANTED: begin
                if (!requests_i[grant_index_q]) begin
                    state_d   = ST_IDLE;
                    grants_d  = '0;
                    busy_d    = 1'b0;
                    pointer_d = next_pointer;
                end else if (WATCHDOG_EN && (counter_q == HOLD_LAST)) begin
                    state_d   = ST_IDLE;
                    grants_d  = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    pointer_d = next_pointer;
                end else if (WATCHDOG_EN) begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            grants_q      <= '0;
            grant_index_q <= '0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            pointer_q     <= '0;
            counter_q     <= '0;
        end else begin
            state_q       <= state_d;
            grants_q      <= grants_d;
            grant_index_q <= grant_index_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            pointer_q     <= pointer_d;
            counter_q     <= counter_d;
        end
    end

    assign grants_o      = grants_q;
    assign grant_index_o = grant_index_q;
    assign busy_o        = busy_q;
    assign timeout_o     = timeout_q;

`ifndef SYNTHESIS
    always @(posedge clock_i) begin
        if (!reset_i) begin
            assert ($onehot0(grants_q))
                else $error("grants not one-hot-or-zero: %b", grants_q);
            assert (busy_q == (|grants_q))
                else $error("busy disagrees with grants");
            assert (!(timeout_q && busy_q))
                else $error("timeout asserted while busy");
            assert (32'(grant_index_q) < 32'(NUMBER_OF_REQUESTERS))
                else $error("grant index out of range");
        end
    end
`endif

endmodule
